// File: rtl/i2c_target_model.sv
// I2C target responder with a byte-wide register file, oversampling SCL/SDA on clk_i.
// Define I2C_TGT_STRETCH_EN to build clock stretching after every ACK bit.
module i2c_target_model #(
  parameter logic [6:0] TargetAddr    = 7'h50,
  parameter int         NumRegs       = 16,
  parameter int         StretchCycles = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_o,
  output logic                       sda_en_o,
  output logic                       scl_o,
  output logic                       scl_en_o,
  output logic                       busy_o,
  output logic                       wr_valid_o,
  output logic [$clog2(NumRegs)-1:0] wr_idx_o,
  output logic [7:0]                 wr_data_o
);
  localparam int IdxW = $clog2(NumRegs);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [6:0]      shift_q, shift_d;
  logic [IdxW-1:0] ptr_q, ptr_d, ptr_inc;
  logic            drive_q, drive_d;
  logic            wr_en, wr_valid_q;
  logic [IdxW-1:0] wr_idx_q;
  logic [7:0]      wr_data_q, byte_in, rd_cur, rd_next;
  logic [7:0]      regs [NumRegs];

  logic [2:0] scl_sh, sda_sh;
  logic       scl_rise, scl_fall, start_det, stop_det, stretching;

  // Shift chains: [0] metastable stage, [1] synchronised, [2] previous sample.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_i};
      sda_sh <= {sda_sh[1:0], sda_i};
    end
  end

  assign scl_rise  = scl_sh[1] & ~scl_sh[2] & ~stretching;
  assign scl_fall  = ~scl_sh[1] & scl_sh[2] & ~stretching;
  assign start_det = scl_sh[1] & scl_sh[2] & ~sda_sh[1] & sda_sh[2];
  assign stop_det  = scl_sh[1] & scl_sh[2] & sda_sh[1] & ~sda_sh[2];

  assign byte_in = {shift_q, sda_sh[1]};
  assign ptr_inc = ptr_q + 1'b1;
  assign rd_cur  = regs[ptr_q];
  assign rd_next = regs[ptr_inc];

`ifdef I2C_TGT_STRETCH_EN
  localparam int CntW = $clog2(StretchCycles + 1);
  logic [CntW-1:0] stretch_q;
  logic            stretch_load;

  // cnt_q == 1 in an ACK state means this falling edge closes an acknowledged bit.
  assign stretch_load = scl_fall && (cnt_q == 4'd1) &&
                        (state_q inside {ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  stretch_q <= '0;
    else if (stretch_load)      stretch_q <= CntW'(StretchCycles);
    else if (stretch_q != '0)   stretch_q <= stretch_q - 1'b1;
  end

  assign stretching = (stretch_q != '0);
`else
  logic unused_stretch;
  assign unused_stretch = ^StretchCycles;
  assign stretching     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      drive_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      drive_q    <= drive_d;
      wr_valid_q <= wr_en;
      if (wr_en) begin
        wr_idx_q  <= ptr_q;
        wr_data_q <= byte_in;
      end
    end
  end

  // NOTE: the register file is reset too, since a host may read any location before writing it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[ptr_q] <= byte_in;
    end
  end

  // ACK states use cnt_q as a phase flag: 0 = waiting for the edge that starts the ACK bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    drive_d = drive_q;
    wr_en   = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ADDR) begin
                state_d = (byte_in[7:1] == TargetAddr) ? ADDR_ACK : IGNORE;
              end else if (state_q == PTR) begin
                ptr_d   = byte_in[IdxW-1:0];
                state_d = PTR_ACK;
              end else begin
                wr_en   = 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              drive_d = 1'b1;
              cnt_d   = 4'd1;
            end else begin
              drive_d = 1'b0;
              cnt_d   = '0;
              if (state_q == ADDR_ACK) begin
                if (shift_q[0]) begin
                  state_d = RDATA;
                  shift_d = rd_cur[6:0];
                  drive_d = ~rd_cur[7];
                end else begin
                  state_d = PTR;
                end
              end else begin
                state_d = WDATA;
                if (state_q == WDATA_ACK) ptr_d = ptr_inc;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              drive_d = 1'b0;
              cnt_d   = '0;
              state_d = RDATA_ACK;
            end else begin
              drive_d = ~shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_sh[1]) state_d = IGNORE;
            else           cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d   = '0;
            ptr_d   = ptr_inc;
            shift_d = rd_next[6:0];
            drive_d = ~rd_next[7];
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_o      = 1'b0;
    scl_o      = 1'b0;
    sda_en_o   = drive_q;
    scl_en_o   = stretching;
    busy_o     = (state_q != IDLE);
    wr_valid_o = wr_valid_q;
    wr_idx_o   = wr_idx_q;
    wr_data_o  = wr_data_q;
  end

endmodule

// File: tb/tb_i2c_target_model.sv
// Bit-banged I2C host driving i2c_target_model, checked against a transaction-level
// register-file model; stretch checks are compiled in with I2C_TGT_STRETCH_EN.
`timescale 1ns/1ps
module tb_i2c_target_model;
  localparam int H     = 6;
  localparam int NREGS = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       host_scl = 1'b1, host_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       sda_o, sda_en_o, scl_o, scl_en_o, busy_o, wr_valid_o;
  logic [3:0] wr_idx_o;
  logic [7:0] wr_data_o;

  assign scl_bus = host_scl & ~scl_en_o;
  assign sda_bus = host_sda & ~sda_en_o;

  i2c_target_model #(.TargetAddr(7'h50), .NumRegs(NREGS), .StretchCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_en_o(sda_en_o), .scl_o(scl_o), .scl_en_o(scl_en_o),
    .busy_o(busy_o), .wr_valid_o(wr_valid_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  m_regs [NREGS];
  int          m_ptr;
  logic [11:0] exp_wr[$];
  logic [11:0] wr_log[$];
  logic [7:0]  tx_q[$];
  logic        sda_seen = 1'b0, scl_seen = 1'b0;
  int          st_run = 0;
  int          st_runs[$];

  always @(negedge clk_i) begin
    if (wr_valid_o) wr_log.push_back({wr_idx_o, wr_data_o});
    if (sda_en_o) sda_seen = 1'b1;
    if (scl_en_o) begin
      scl_seen = 1'b1;
      st_run++;
    end else if (st_run != 0) begin
      st_runs.push_back(st_run);
      st_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_bus !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (scl_bus !== 1'b1) check("scl_release_timeout", scl_bus, 1);
  endtask

  task automatic bus_start();
    host_sda = 1'b1; tick(H);
    host_scl = 1'b1; wait_scl_high(); tick(H);
    host_sda = 1'b0; tick(H);
    host_scl = 1'b0; tick(H);
  endtask

  task automatic bus_stop();
    host_sda = 1'b0; tick(H);
    host_scl = 1'b1; wait_scl_high(); tick(H);
    host_sda = 1'b1; tick(H);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    host_sda = b; tick(H);
    host_scl = 1'b1; wait_scl_high(); tick(H / 2);
    seen = sda_bus; tick(H - H / 2);
    host_scl = 1'b0; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  task automatic check_wr_log();
    check("wr_count", wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check("wr_entry", wr_log[i], exp_wr[i]);
  endtask

  // First data byte sets the pointer; the rest are written at consecutive wrapping indices.
  task automatic xfer_write(input logic [6:0] addr);
    logic ack;
    logic hit;
    hit = (addr == 7'h50);
    wr_log.delete();
    exp_wr.delete();
    sda_seen = 1'b0;
    bus_start();
    check("busy_after_start", busy_o, 1);
    send_byte({addr, 1'b0}, ack);
    check("addr_ack", ack, hit);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], ack);
      check("byte_ack", ack, hit);
      if (hit) begin
        if (i == 0) begin
          m_ptr = tx_q[i] % NREGS;
        end else begin
          exp_wr.push_back({4'(m_ptr), tx_q[i]});
          m_regs[m_ptr] = tx_q[i];
          m_ptr = (m_ptr + 1) % NREGS;
        end
      end
    end
    check("busy_before_stop", busy_o, 1);
    bus_stop();
    check("busy_after_stop", busy_o, 0);
    check("sda_idle_after_stop", sda_en_o, 0);
    if (!hit) check("sda_never_driven", sda_seen, 0);
    check_wr_log();
  endtask

  // Reads n bytes, ACKing all but the last; a NACKed byte leaves the pointer where it was.
  task automatic xfer_read(input int n, input logic set_ptr, input int ptr);
    logic       ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hA0, ack);
      check("rd_addr_w_ack", ack, 1);
      send_byte(8'(ptr), ack);
      check("rd_ptr_ack", ack, 1);
      m_ptr = ptr % NREGS;
      bus_start();
    end
    send_byte(8'hA1, ack);
    check("rd_addr_r_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i < n - 1);
      check("rd_data", d, m_regs[m_ptr]);
      if (i < n - 1) m_ptr = (m_ptr + 1) % NREGS;
    end
    tick(2);
    check("sda_released_after_nack", sda_en_o, 0);
    bus_stop();
    check("busy_after_rd_stop", busy_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] pb;
    int         ptr, n;

    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    tick(4);
    check("reset_outputs",
          {sda_o, sda_en_o, scl_o, scl_en_o, busy_o, wr_valid_o, wr_idx_o, wr_data_o}, 0);
    rst_i = 1'b0;
    tick(4);

    st_runs.delete();
    tx_q.delete();
    tx_q.push_back(8'h03); tx_q.push_back(8'h5A); tx_q.push_back(8'hC3);
    xfer_write(7'h50);
`ifdef I2C_TGT_STRETCH_EN
    check("stretch_runs", st_runs.size(), 4);
    foreach (st_runs[i]) check("stretch_len", st_runs[i], 8);
`endif
    xfer_read(2, 1'b1, 3);

    tx_q.delete();
    tx_q.push_back(8'h00);
    xfer_write(7'h51);

    tx_q.delete();
    tx_q.push_back(8'h0F); tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    xfer_write(7'h50);
    xfer_read(2, 1'b1, 15);

    for (int k = 0; k < 4; k++) begin
      ptr = $urandom_range(0, NREGS - 1);
      n   = $urandom_range(1, 4);
      tx_q.delete();
      tx_q.push_back(8'(ptr));
      for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
      xfer_write(7'h50);
      xfer_read(n, 1'b1, ptr);
    end

    // STOP four bits into a data byte: nothing may be written.
    wr_log.delete();
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    m_ptr = 5;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
    bus_stop();
    check("abort_no_write", wr_log.size(), 0);
    check("abort_idle", busy_o, 0);
    check("abort_sda", sda_en_o, 0);
    xfer_read(1, 1'b1, 5);

    // Reset while the target is driving the pointer-byte ACK.
    pb = 8'h07;
    bus_start();
    send_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) clock_bit(pb[i], s);
    check("ack_driven_before_reset", sda_en_o, 1);
    rst_i = 1'b1;
    #1;
    check("reset_releases_sda", sda_en_o, 0);
    check("reset_clears_busy", busy_o, 0);
    host_sda = 1'b1;
    host_scl = 1'b1;
    tick(4);
    rst_i = 1'b0;
    tick(4);
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    xfer_read(NREGS, 1'b0, 0);

`ifndef I2C_TGT_STRETCH_EN
    check("scl_never_stretched", scl_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
